sobel_stream_engine: RTL and testbench

Parametrised successor to the single-mode Sobel controller. It streams one frame from BRAM0 through a 2-line buffer and a 3x3 window, then writes results to BRAM1. It supports runtime image dimensions, three modes (copy, Sobel magnitude, thresholded Sobel), dimension checking, abort, and a clean done/drain sequence. It sits between the frame-capture block (BRAM0 writer) and the display/readback path (BRAM1 reader).

---
 rtl/sobel_stream_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_engine.sv
// Streams one frame from BRAM0 through two line buffers and a 3x3 window, then
// writes copy / Sobel magnitude / thresholded Sobel results to BRAM1.
module sobel_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int MAX_W      = 320,
  parameter int MAX_H      = 240,
  parameter int DIM_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [1:0]            i_mode,
  input  logic [DIM_WIDTH-1:0]  i_img_w,
  input  logic [DIM_WIDTH-1:0]  i_img_h,
  input  logic [DATA_WIDTH-1:0] i_thresh,
  output logic                  b0_ce1,
  output logic                  b0_we1,
  output logic [ADDR_WIDTH-1:0] b0_addr1,
  output logic [DATA_WIDTH-1:0] b0_d1,
  input  logic [DATA_WIDTH-1:0] b0_q1,
  output logic                  b1_ce1,
  output logic                  b1_we1,
  output logic [ADDR_WIDTH-1:0] b1_addr1,
  output logic [DATA_WIDTH-1:0] b1_d1,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            o_dbg_state
);

  localparam int SW  = DATA_WIDTH + 3;
  localparam int LBW = $clog2(MAX_W);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [DATA_WIDTH-1:0] thresh_q, thresh_d;
  logic [ADDR_WIDTH-1:0] total_q, total_d, rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  err_q, err_d;
  logic                  vld_q, vld_d, s1_vld_q, s1_vld_d, wvld_q, wvld_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic [DATA_WIDTH-1:0] lb1_q [MAX_W];
  logic [DATA_WIDTH-1:0] lb2_q [MAX_W];

  logic                  rd_en, b1_we, cfg_bad, in_frame;
  logic [ADDR_WIDTH-1:0] area;
  logic [LBW-1:0]        xi;
  logic [DATA_WIDTH-1:0] lb_top, lb_mid;
  logic signed [SW-1:0]  gx, gy, ax, ay;
  logic [SW:0]           mag;
  logic [DATA_WIDTH-1:0] mag_sat, sobel_out;

  function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign xi     = x_q[LBW-1:0];
  assign lb_top = lb2_q[xi];
  assign lb_mid = lb1_q[xi];
  assign area   = ADDR_WIDTH'(w_q) * ADDR_WIDTH'(h_q);

  // Copy needs only a non-empty frame; Sobel needs at least one full window.
  always_comb begin
    cfg_bad = (w_q > DIM_WIDTH'(MAX_W)) || (h_q > DIM_WIDTH'(MAX_H)) || (mode_q == 2'd3);
    if (mode_q == 2'd0) cfg_bad = cfg_bad || (w_q == '0) || (h_q == '0);
    else                cfg_bad = cfg_bad || (w_q < DIM_WIDTH'(3)) || (h_q < DIM_WIDTH'(3));
  end

  always_comb begin
    gx = (ext(win_q[2]) + (ext(win_q[5]) <<< 1) + ext(win_q[8]))
       - (ext(win_q[0]) + (ext(win_q[3]) <<< 1) + ext(win_q[6]));
    gy = (ext(win_q[6]) + (ext(win_q[7]) <<< 1) + ext(win_q[8]))
       - (ext(win_q[0]) + (ext(win_q[1]) <<< 1) + ext(win_q[2]));
    ax = gx[SW-1] ? -gx : gx;
    ay = gy[SW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    mag_sat = (|mag[SW:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];
    if (mode_q == 2'd2) sobel_out = (mag_sat >= thresh_q) ? '1 : '0;
    else                sobel_out = mag_sat;
  end

  assign in_frame = (state_q == S_CHECK) || (state_q == S_READ) || (state_q == S_DRAIN);

  // vld_q marks the cycle b0_q1 carries the pixel addressed one cycle earlier.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    w_d       = w_q;
    h_d       = h_q;
    thresh_d  = thresh_q;
    total_d   = total_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;
    x_d       = x_q;
    y_d       = y_q;
    win_d     = win_q;
    rd_en     = 1'b0;

    if (vld_q) begin
      if (x_q == w_q - DIM_WIDTH'(1)) begin
        x_d = '0;
        y_d = y_q + DIM_WIDTH'(1);
      end else begin
        x_d = x_q + DIM_WIDTH'(1);
      end
      win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = lb_top;
      win_d[3] = win_q[4]; win_d[4] = win_q[5]; win_d[5] = lb_mid;
      win_d[6] = win_q[7]; win_d[7] = win_q[8]; win_d[8] = b0_q1;
    end
    s1_vld_d = vld_q && (mode_q != 2'd0) && (x_q >= DIM_WIDTH'(2)) && (y_q >= DIM_WIDTH'(2));
    wvld_d   = (mode_q == 2'd0) ? vld_q : s1_vld_q;
    wdata_d  = (mode_q == 2'd0) ? b0_q1 : sobel_out;
    waddr_d  = wvld_q ? waddr_q + ADDR_WIDTH'(1) : waddr_q;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          mode_d    = i_mode;
          w_d       = i_img_w;
          h_d       = i_img_h;
          thresh_d  = i_thresh;
          err_d     = 1'b0;
          rd_addr_d = '0;
          waddr_d   = '0;
          x_d       = '0;
          y_d       = '0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        total_d = area;
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_en     = 1'b1;
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        if (rd_addr_q == total_q - ADDR_WIDTH'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!vld_q && !s1_vld_q && !wvld_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (i_abort && in_frame) begin
      state_d  = S_IDLE;
      rd_en    = 1'b0;
      s1_vld_d = 1'b0;
      wvld_d   = 1'b0;
    end
    vld_d = rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      w_q       <= '0;
      h_q       <= '0;
      thresh_q  <= '0;
      total_q   <= '0;
      rd_addr_q <= '0;
      waddr_q   <= '0;
      err_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      vld_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      wvld_q    <= 1'b0;
      wdata_q   <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      w_q       <= w_d;
      h_q       <= h_d;
      thresh_q  <= thresh_d;
      total_q   <= total_d;
      rd_addr_q <= rd_addr_d;
      waddr_q   <= waddr_d;
      err_q     <= err_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vld_q     <= vld_d;
      s1_vld_q  <= s1_vld_d;
      wvld_q    <= wvld_d;
      wdata_q   <= wdata_d;
      win_q     <= win_d;
    end
  end

  // Each column holds the two rows above the arriving pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else if (vld_q) begin
      lb2_q[xi] <= lb_mid;
      lb1_q[xi] <= b0_q1;
    end
  end

  assign b1_we = wvld_q && ((state_q == S_READ) || (state_q == S_DRAIN)) && !i_abort;

  assign b0_ce1      = rd_en;
  assign b0_we1      = 1'b0;
  assign b0_addr1    = rd_en ? rd_addr_q : '0;
  assign b0_d1       = '0;
  assign b1_ce1      = b1_we;
  assign b1_we1      = b1_we;
  assign b1_addr1    = b1_we ? waddr_q : '0;
  assign b1_d1       = b1_we ? wdata_q : '0;
  assign o_idle      = (state_q == S_IDLE);
  assign o_busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Directed bench for sobel_stream_engine: BRAM0 model, frame-level reference
// model feeding an expected-write queue, and a per-cycle write checker.
module tb_sobel_stream_engine;
  localparam int DW  = 8;
  localparam int AW  = 17;
  localparam int DIM = 9;

  logic          clk, rst;
  logic          i_start, i_abort;
  logic [1:0]    i_mode;
  logic [DIM-1:0] i_img_w, i_img_h;
  logic [DW-1:0] i_thresh;
  logic          b0_ce1, b0_we1, b1_ce1, b1_we1;
  logic [AW-1:0] b0_addr1, b1_addr1;
  logic [DW-1:0] b0_d1, b0_q1, b1_d1;
  logic          o_idle, o_busy, o_done, o_err;
  logic [2:0]    o_dbg_state;

  sobel_stream_engine dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_img_w(i_img_w), .i_img_h(i_img_h), .i_thresh(i_thresh),
    .b0_ce1(b0_ce1), .b0_we1(b0_we1), .b0_addr1(b0_addr1), .b0_d1(b0_d1), .b0_q1(b0_q1),
    .b1_ce1(b1_ce1), .b1_we1(b1_we1), .b1_addr1(b1_addr1), .b1_d1(b1_d1),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] b1mem [0:1023];
  always @(posedge clk) if (b0_ce1) b0_q1 <= mem0[b0_addr1[9:0]];

  // scoreboard
  logic [AW+DW-1:0] exp_q[$];
  int n_vec = 0, n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [AW-1:0] rd_next = '0;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (o_idle) rd_next = '0;
    if (b0_ce1) begin
      rd_cnt++;
      n_vec++;
      if (b0_addr1 !== rd_next) begin
        n_err++;
        $display("FAIL b0_addr: got %0d, expected %0d", b0_addr1, rd_next);
      end
      rd_next = rd_next + 1'b1;
    end
    if (b1_we1) begin
      wr_cnt++;
      n_vec++;
      b1mem[b1_addr1[9:0]] = b1_d1;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL b1_write: unexpected write addr %0d data %0d", b1_addr1, b1_d1);
      end else begin
        e = exp_q.pop_front();
        if ({b1_addr1, b1_d1} !== e || b1_ce1 !== 1'b1) begin
          n_err++;
          $display("FAIL b1_write: got addr %0d data %0d ce %0b, expected addr %0d data %0d ce 1",
                   b1_addr1, b1_d1, b1_ce1, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (o_done) done_cnt++;
  end

  // reference model: whole-frame arithmetic over the BRAM0 image
  function automatic int px(input int w, input int x, input int y);
    return int'(mem0[y*w + x]);
  endfunction

  function automatic bit build_expected(input int mode, input int w, input int h, input int th);
    int k, gx, gy, mag;
    exp_q.delete();
    if (mode == 3 || w > 320 || h > 240) return 1'b1;
    if (mode == 0 && (w < 1 || h < 1)) return 1'b1;
    if (mode != 0 && (w < 3 || h < 3)) return 1'b1;
    if (mode == 0) begin
      for (int i = 0; i < w*h; i++) exp_q.push_back({AW'(i), mem0[i]});
      return 1'b0;
    end
    k = 0;
    for (int cy = 1; cy < h-1; cy++) begin
      for (int cx = 1; cx < w-1; cx++) begin
        gx = (px(w,cx+1,cy-1) + 2*px(w,cx+1,cy) + px(w,cx+1,cy+1))
           - (px(w,cx-1,cy-1) + 2*px(w,cx-1,cy) + px(w,cx-1,cy+1));
        gy = (px(w,cx-1,cy+1) + 2*px(w,cx,cy+1) + px(w,cx+1,cy+1))
           - (px(w,cx-1,cy-1) + 2*px(w,cx,cy-1) + px(w,cx+1,cy-1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        if (mode == 2) mag = (mag >= th) ? 255 : 0;
        exp_q.push_back({AW'(k), DW'(mag)});
        k++;
      end
    end
    return 1'b0;
  endfunction

  // driver tasks
  int  f_done0, f_wr0, f_nexp;
  bit  f_err;

  task automatic start_frame(input int mode, input int w, input int h, input int th);
    f_err   = build_expected(mode, w, h, th);
    f_nexp  = exp_q.size();
    f_done0 = done_cnt;
    f_wr0   = wr_cnt;
    @(posedge clk); #1;
    i_start = 1'b1; i_abort = 1'b0;
    i_mode = 2'(mode); i_img_w = DIM'(w); i_img_h = DIM'(h); i_thresh = DW'(th);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - f_done0, 1);
    check({tag, "_writes"}, wr_cnt - f_wr0, f_nexp);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_err"}, int'(o_err), int'(f_err));
    check({tag, "_idle"}, int'(o_idle), 1);
  endtask

  task automatic load_ramp(input int w, input int h);
    for (int y = 0; y < h; y++) for (int x = 0; x < w; x++) mem0[y*w + x] = DW'(10*x);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_b0_ce1"}, int'(b0_ce1), 0);
    check({tag, "_b1_we1"}, int'(b1_we1), 0);
    check({tag, "_b0_addr"}, int'(b0_addr1), 0);
    check({tag, "_o_idle"}, int'(o_idle), 1);
    check({tag, "_o_busy"}, int'(o_busy), 0);
    check({tag, "_o_done"}, int'(o_done), 0);
    check({tag, "_o_err"}, int'(o_err), 0);
  endtask

  initial begin
    int rd0, d0;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_mode = '0;
    i_img_w = '0; i_img_h = '0; i_thresh = '0; b0_q1 = '0;
    for (int i = 0; i < 1024; i++) begin mem0[i] = '0; b1mem[i] = '0; end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // copy 4x3, with a stray start during READ that must be ignored
    for (int i = 0; i < 12; i++) mem0[i] = DW'(i);
    start_frame(0, 4, 3, 0);
    check("model_copy_n", exp_q.size(), 12);
    repeat (3) @(posedge clk); #1;
    check("copy_busy_in_read", int'(o_busy), 1);
    i_start = 1'b1; i_mode = 2'd1; i_img_w = DIM'(5);
    @(posedge clk); #1 i_start = 1'b0;
    finish_frame("copy");
    check("copy_b1_0", int'(b1mem[0]), 0);
    check("copy_b1_5", int'(b1mem[5]), 5);
    check("copy_b1_11", int'(b1mem[11]), 11);

    // Sobel ramp 5x4: every output is 80
    load_ramp(5, 4);
    start_frame(1, 5, 4, 0);
    check("model_ramp_n", exp_q.size(), 6);
    check("model_ramp_v", int'(exp_q[5][DW-1:0]), 80);
    finish_frame("ramp");
    for (int i = 0; i < 6; i++) check("ramp_b1", int'(b1mem[i]), 80);

    // saturation: bottom row 255 gives Gy=1020, clipped
    for (int i = 0; i < 9; i++) mem0[i] = (i >= 6) ? 8'd255 : 8'd0;
    b1mem[0] = '0;
    start_frame(1, 3, 3, 0);
    check("model_sat_v", int'(exp_q[0][DW-1:0]), 255);
    finish_frame("sat");
    check("sat_b1", int'(b1mem[0]), 255);

    // threshold at and just above the ramp magnitude
    load_ramp(5, 4);
    start_frame(2, 5, 4, 80);
    finish_frame("thr80");
    for (int i = 0; i < 6; i++) check("thr80_b1", int'(b1mem[i]), 255);
    start_frame(2, 5, 4, 81);
    finish_frame("thr81");
    for (int i = 0; i < 6; i++) check("thr81_b1", int'(b1mem[i]), 0);

    // bad configs: no BRAM activity, sticky err, done still pulses
    rd0 = rd_cnt;
    start_frame(1, 2, 10, 0);
    finish_frame("bad_w2");
    check("bad_w2_reads", rd_cnt - rd0, 0);
    start_frame(3, 5, 4, 0);
    finish_frame("bad_mode3");
    start_frame(0, 321, 2, 0);
    finish_frame("bad_wide");
    check("bad_total_reads", rd_cnt - rd0, 0);

    // next valid start clears err; pseudo-random texture in both Sobel modes
    for (int i = 0; i < 30; i++) mem0[i] = DW'((i * 37 + 11) % 256);
    start_frame(1, 6, 5, 0);
    check("err_cleared", int'(o_err), 0);
    finish_frame("tex");
    start_frame(2, 6, 5, 100);
    finish_frame("tex_thr");

    // smallest copy frame
    mem0[0] = 8'd77;
    start_frame(0, 1, 1, 0);
    finish_frame("copy1x1");
    check("copy1x1_b1", int'(b1mem[0]), 77);

    // abort mid-READ
    load_ramp(5, 4);
    start_frame(1, 5, 4, 0);
    repeat (5) @(posedge clk); #1;
    check("abort_pre_busy", int'(o_busy), 1);
    d0 = done_cnt;
    i_abort = 1'b1; #1;
    check("abort_ce_drop", int'(b0_ce1), 0);
    check("abort_we_drop", int'(b1_we1), 0);
    @(posedge clk); #1 i_abort = 1'b0;
    check("abort_idle", int'(o_idle), 1);
    exp_q.delete();
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_err", int'(o_err), 0);

    // reset mid-frame, then a clean frame
    for (int i = 0; i < 12; i++) mem0[i] = DW'(100 + i);
    start_frame(0, 4, 3, 0);
    repeat (4) @(posedge clk); #1;
    rst = 1'b1; #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    start_frame(0, 4, 3, 0);
    finish_frame("post_rst");
    check("post_rst_b1_11", int'(b1mem[11]), 111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
